clk_gen_ctrl: RTL and testbench
===============================

CLK_GEN_CTRL -- requirements
Module: clk_gen_ctrl

Interface
REQ-001 SHALL have parameter sel_width_p, 4, generator select width.
REQ-002 SHALL have parameter hold_cycles_p, 16, cycles generator reset is held per reconfiguration (legal range >=2).
REQ-003 SHALL have parameter settle_cycles_p, 64, post-reset settle cycles before measurement (legal range >=1).
REQ-004 SHALL have parameter window_cycles_p, 1024, measurement window length in cycles (legal range >=1).
REQ-005 SHALL have parameter count_width_p, 16, measurement counter width.
REQ-006 SHALL have ports: clk_i  in  1  reference clock; the only clock.
REQ-007 SHALL have ports: reset_n_i  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: cfg_v_i  in  1  single-config request valid; cfg_sel_i  in  sel_width_p  requested select; cfg_ready_o  out  1  request accepted when high with cfg_v_i.
REQ-009 SHALL have ports: sweep_start_i  in  1  request sweep of all 2**sel_width_p selects, ascending.
REQ-010 SHALL have ports: gen_reset_o  out  1  active-high reset to clock generator; gen_select_o  out  sel_width_p  generator select.
REQ-011 SHALL have ports: gen_tick_i  in  1  level already synchronized into clk_i domain (divided generator output).
REQ-012 SHALL have ports: meas_v_o  out  1  one-cycle result strobe; meas_sel_o  out  sel_width_p  select measured; meas_count_o  out  count_width_p  rising-edge count; busy_o  out  1  high when not IDLE.

Function
REQ-013 SHALL implement states IDLE, RESET_HOLD, SETTLE, MEASURE, REPORT.
REQ-014 cfg_ready_o SHALL be 1 only in IDLE; sweep_start_i SHALL be ignored outside IDLE.
REQ-015 In IDLE, cfg_v_i & cfg_ready_o (cycle 0) SHALL latch cfg_sel_i, clear sweep flag, enter RESET_HOLD at cycle 1.
REQ-016 In IDLE, sweep_start_i without cfg_v_i SHALL latch select 0, set sweep flag, enter RESET_HOLD; cfg_v_i SHALL win when both asserted.
REQ-017 RESET_HOLD SHALL last exactly hold_cycles_p cycles (cycles 1..H) with gen_reset_o=1.
REQ-018 gen_select_o SHALL change to the latched select at the start of cycle 2, never while gen_reset_o=0.
REQ-019 SETTLE SHALL last settle_cycles_p cycles (H+1..H+S) with gen_reset_o=0; gen_tick_i ignored.
REQ-020 MEASURE SHALL last window_cycles_p cycles (H+S+1..H+S+W), counting cycles where gen_tick_i=1 and its registered prior value=0; prior-value register SHALL update every cycle so an edge from SETTLE into first MEASURE cycle counts.
REQ-021 Edge counter SHALL clear on MEASURE entry and saturate at 2**count_width_p-1.
REQ-022 REPORT SHALL be one cycle (H+S+W+1) with meas_v_o=1; meas_sel_o/meas_count_o SHALL update in that cycle and hold until next REPORT.
REQ-023 After REPORT: if sweep flag and select != all-ones, select+1 and enter RESET_HOLD; otherwise enter IDLE, clear sweep flag.
REQ-024 In IDLE after a completed sequence, gen_reset_o SHALL remain 0 and gen_select_o SHALL hold the last select (generator keeps running).
REQ-025 busy_o SHALL equal (state != IDLE).

Reset
REQ-026 reset_n_i=0 at any clock edge, including mid-sequence, SHALL force next cycle: IDLE, gen_reset_o=1, gen_select_o=0, cfg_ready_o=1, meas_v_o=0, meas_sel_o=0, meas_count_o=0, busy_o=0, sweep flag 0, counters 0.
REQ-027 After reset, gen_reset_o SHALL stay 1 until the first accepted request.

Structure
REQ-028 Package clk_gen_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-029 One sub-module clk_gen_ctrl_timer (loadable down-counter with zero flag) SHALL time RESET_HOLD, SETTLE, MEASURE.

Verification (H=4, S=8, W=32, count_width_p=8)
REQ-030 cfg_sel_i=5 accepted at cycle 0 -> gen_reset_o=1 cycles 1-4, gen_select_o=5 from cycle 2, meas_v_o at cycle 45 only.
REQ-031 gen_tick_i toggling every 2 cycles through MEASURE -> meas_count_o=8, meas_sel_o=5.
REQ-032 sweep_start_i in IDLE -> 16 meas_v_o pulses, meas_sel_o 0..15, 45 cycles apart, then IDLE with gen_select_o=15, gen_reset_o=0.
REQ-033 cfg_v_i and sweep_start_i same cycle with cfg_sel_i=3 -> single measurement sel 3, return to IDLE.
REQ-034 reset_n_i=0 during MEASURE of sweep select 7 -> next cycle IDLE, gen_reset_o=1, gen_select_o=0, no meas_v_o.
REQ-035 gen_tick_i toggling every cycle with W=600, count_width_p=8 -> meas_count_o=255 (saturated).

Source files
------------

// File: rtl/clk_gen_ctrl_pkg.sv
// clk_gen_ctrl_pkg
// Shared definitions for the clock-generator sequencing controller:
// default parameter values, the internal timer width and the FSM state enum.
package clk_gen_ctrl_pkg;

  localparam int sel_width_def     = 4;
  localparam int hold_cycles_def   = 16;
  localparam int settle_cycles_def = 64;
  localparam int window_cycles_def = 1024;
  localparam int count_width_def   = 16;

  // Wide enough for any practical hold/settle/window length.
  localparam int timer_width = 32;

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    SETTLE,
    MEASURE,
    REPORT
  } state_t;

endpackage

// File: rtl/clk_gen_ctrl_timer.sv
// clk_gen_ctrl_timer
// Loadable down-counter with terminal-count flag. Loading N-1 makes zero
// assert on the N-th cycle after the load edge.
// Ports:
//   clk      reference clock
//   reset_n  synchronous active-low reset (count cleared)
//   load     load load_val on the next edge
//   load_val value to load
//   zero     count has reached zero
module clk_gen_ctrl_timer
  import clk_gen_ctrl_pkg::*;
#(
  parameter int width_p = timer_width
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [width_p-1:0] load_val,
  output logic               zero
);

  logic [width_p-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl
// Sequences a clock generator through reset, settle and a frequency
// measurement window, either for one requested select or a sweep of all
// selects, and reports the rising-edge count of the divided generator output.
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | waiting for a config or sweep request
// RESET_HOLD | generator held in reset, select applied
// SETTLE     | generator running, output ignored
// MEASURE    | counting rising edges of gen_tick_i
// REPORT     | one-cycle result strobe
//
// Ports:
//   clk_i, reset_n_i                  clock, synchronous active-low reset
//   cfg_v_i, cfg_sel_i, cfg_ready_o   single-select request handshake
//   sweep_start_i                     request sweep of every select
//   gen_reset_o, gen_select_o         generator control
//   gen_tick_i                        synchronized divided generator output
//   meas_v_o, meas_sel_o, meas_count_o  measurement result
//   busy_o                            controller not idle
module clk_gen_ctrl
  import clk_gen_ctrl_pkg::*;
#(
  parameter int sel_width_p     = sel_width_def,
  parameter int hold_cycles_p   = hold_cycles_def,
  parameter int settle_cycles_p = settle_cycles_def,
  parameter int window_cycles_p = window_cycles_def,
  parameter int count_width_p   = count_width_def
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cfg_v_i,
  input  logic [sel_width_p-1:0]   cfg_sel_i,
  output logic                     cfg_ready_o,
  input  logic                     sweep_start_i,
  output logic                     gen_reset_o,
  output logic [sel_width_p-1:0]   gen_select_o,
  input  logic                     gen_tick_i,
  output logic                     meas_v_o,
  output logic [sel_width_p-1:0]   meas_sel_o,
  output logic [count_width_p-1:0] meas_count_o,
  output logic                     busy_o
);

  state_t                   state_q, state_d;
  logic                     tmr_load, tmr_zero;
  logic [timer_width-1:0]   tmr_val;

  logic [sel_width_p-1:0]   sel_q, gen_sel_q, meas_sel_q;
  logic                     sweep_q, idle_rst_q, tick_q, tick_edge, last_sel;
  logic [count_width_p-1:0] cnt_q, cnt_nxt, meas_cnt_q;

  clk_gen_ctrl_timer #(.width_p(timer_width)) u_timer (
    .clk      (clk_i),
    .reset_n  (reset_n_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign last_sel  = (sel_q == '1);
  assign tick_edge = gen_tick_i & ~tick_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (cfg_v_i || sweep_start_i) begin
          state_d  = RESET_HOLD;
          tmr_load = 1'b1;
          tmr_val  = timer_width'(hold_cycles_p - 1);
        end
      end
      RESET_HOLD: begin
        if (tmr_zero) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = timer_width'(settle_cycles_p - 1);
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d  = MEASURE;
          tmr_load = 1'b1;
          tmr_val  = timer_width'(window_cycles_p - 1);
        end
      end
      MEASURE: begin
        if (tmr_zero) state_d = REPORT;
      end
      REPORT: begin
        if (sweep_q && !last_sel) begin
          state_d  = RESET_HOLD;
          tmr_load = 1'b1;
          tmr_val  = timer_width'(hold_cycles_p - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating edge count including the edge seen in the current cycle,
  // so the final window cycle is captured into the result register.
  always_comb begin
    cnt_nxt = cnt_q;
    if (tick_edge && (cnt_q != '1)) cnt_nxt = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sel_q      <= '0;
      sweep_q    <= 1'b0;
      idle_rst_q <= 1'b1;
      gen_sel_q  <= '0;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
      meas_sel_q <= '0;
      meas_cnt_q <= '0;
    end else begin
      // Tracked in every state so an edge right at MEASURE entry counts.
      tick_q <= gen_tick_i;
      case (state_q)
        IDLE: begin
          if (cfg_v_i) begin
            sel_q      <= cfg_sel_i;
            sweep_q    <= 1'b0;
            idle_rst_q <= 1'b0;
          end else if (sweep_start_i) begin
            sel_q      <= '0;
            sweep_q    <= 1'b1;
            idle_rst_q <= 1'b0;
          end
        end
        // Applied from the second hold cycle onward, always under reset.
        RESET_HOLD: gen_sel_q <= sel_q;
        SETTLE: begin
          if (tmr_zero) cnt_q <= '0;
        end
        MEASURE: begin
          cnt_q <= cnt_nxt;
          if (tmr_zero) begin
            meas_cnt_q <= cnt_nxt;
            meas_sel_q <= sel_q;
          end
        end
        REPORT: begin
          if (sweep_q && !last_sel) sel_q   <= sel_q + 1'b1;
          else                      sweep_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // After reset the generator stays in reset until the first request;
  // after a completed sequence it keeps running on the last select.
  assign gen_reset_o  = (state_q == RESET_HOLD) || ((state_q == IDLE) && idle_rst_q);
  assign gen_select_o = gen_sel_q;
  assign cfg_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign meas_v_o     = (state_q == REPORT);
  assign meas_sel_o   = meas_sel_q;
  assign meas_count_o = meas_cnt_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// tb_clk_gen_ctrl
// Self-checking bench for clk_gen_ctrl (H=4, S=8, W=32, 8-bit count) plus a
// second instance with W=600 for counter saturation.
module tb_clk_gen_ctrl;

  localparam int H = 4;
  localparam int S = 8;
  localparam int W = 32;
  localparam int P = H + S + W + 1;  // cycles per measurement, request to REPORT

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n_i, cfg_v_i, sweep_start_i, gen_tick_i;
  logic [3:0] cfg_sel_i;
  logic       cfg_ready_o, gen_reset_o, meas_v_o, busy_o;
  logic [3:0] gen_select_o, meas_sel_o;
  logic [7:0] meas_count_o;

  logic       cfg_v2, sweep2, tick2;
  logic [3:0] sel2;
  logic       ready2, grst2, mv2, busy2;
  logic [3:0] gsel2, msel2;
  logic [7:0] mcnt2;

  clk_gen_ctrl #(.sel_width_p(4), .hold_cycles_p(H), .settle_cycles_p(S),
                 .window_cycles_p(W), .count_width_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .cfg_v_i(cfg_v_i), .cfg_sel_i(cfg_sel_i),
    .cfg_ready_o(cfg_ready_o), .sweep_start_i(sweep_start_i), .gen_reset_o(gen_reset_o),
    .gen_select_o(gen_select_o), .gen_tick_i(gen_tick_i), .meas_v_o(meas_v_o),
    .meas_sel_o(meas_sel_o), .meas_count_o(meas_count_o), .busy_o(busy_o));

  clk_gen_ctrl #(.sel_width_p(4), .hold_cycles_p(H), .settle_cycles_p(S),
                 .window_cycles_p(600), .count_width_p(8)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n_i), .cfg_v_i(cfg_v2), .cfg_sel_i(sel2),
    .cfg_ready_o(ready2), .sweep_start_i(sweep2), .gen_reset_o(grst2),
    .gen_select_o(gsel2), .gen_tick_i(tick2), .meas_v_o(mv2),
    .meas_sel_o(msel2), .meas_count_o(mcnt2), .busy_o(busy2));

  int checks = 0;
  int errors = 0;

  // Reference model state carried between sequences.
  logic [3:0] m_gsel;
  logic       m_grst;
  logic [3:0] m_msel;
  logic [7:0] m_mcnt;

  bit t[0:1023];
  int ecnt[0:15];

  typedef struct {
    bit         cfg;
    logic [3:0] sel;
    bit         sw;
    int         mode;       // 0 random ticks, 1 toggle every 2 cycles, 2 toggle every cycle
    logic [3:0] exp_first;
    int         exp_n;
    logic [3:0] exp_last;
    int         exp_cnt;    // -1: only the reference model applies
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Runs one request (single or sweep) from IDLE to a few idle cycles past
  // completion, checking every output every cycle against the model.
  task automatic run_seq(input vec_t v, input bit noise);
    int n, total, m, r, cnt;
    logic [3:0] s, e_gsel;
    logic e_busy, e_rst, e_v;
    n = v.exp_n;
    total = P * n + 3;
    for (int i = 0; i < total; i++)
      t[i] = (v.mode == 0) ? bit'($urandom % 2) : (v.mode == 1) ? bit'((i / 2) % 2) : bit'(i % 2);
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      for (int i = P * k + H + S + 1; i <= P * k + H + S + W; i++)
        if (t[i] && !t[i-1]) cnt++;
      ecnt[k] = (cnt > 255) ? 255 : cnt;
    end
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      cfg_v_i       = (c == 0) ? v.cfg : (noise && c <= P * n) ? 1'($urandom % 2) : 1'b0;
      cfg_sel_i     = (c == 0) ? v.sel : 4'($urandom);
      sweep_start_i = (c == 0) ? v.sw : (noise && c <= P * n) ? 1'($urandom % 2) : 1'b0;
      gen_tick_i    = t[c];
      @(negedge clk);
      if (c == 0) begin
        e_busy = 1'b0; e_rst = m_grst; e_gsel = m_gsel; e_v = 1'b0;
      end else if (c <= P * n) begin
        m = (c - 1) / P;
        r = (c - 1) % P + 1;
        s = v.exp_first + 4'(m);
        e_busy = 1'b1;
        e_rst  = (r <= H);
        e_gsel = (r >= 2) ? s : ((m == 0) ? m_gsel : s - 4'd1);
        e_v    = (r == P);
        if (r == P) begin
          m_msel = s;
          m_mcnt = 8'(ecnt[m]);
        end
      end else begin
        e_busy = 1'b0; e_rst = 1'b0; e_gsel = v.exp_first + 4'(n - 1); e_v = 1'b0;
      end
      chk("busy",       c, 32'(busy_o),       32'(e_busy));
      chk("cfg_ready",  c, 32'(cfg_ready_o),  32'(!e_busy));
      chk("gen_reset",  c, 32'(gen_reset_o),  32'(e_rst));
      chk("gen_select", c, 32'(gen_select_o), 32'(e_gsel));
      chk("meas_v",     c, 32'(meas_v_o),     32'(e_v));
      chk("meas_sel",   c, 32'(meas_sel_o),   32'(m_msel));
      chk("meas_count", c, 32'(meas_count_o), 32'(m_mcnt));
    end
    m_gsel = v.exp_first + 4'(n - 1);
    m_grst = 1'b0;
  endtask

  initial begin
    int pulses, bad, at;
    bit seen;
    vec_t rv;

    vecs[0] = '{cfg:1, sel:4'd5,  sw:0, mode:1, exp_first:4'd5,  exp_n:1,  exp_last:4'd5,  exp_cnt:8};
    vecs[1] = '{cfg:1, sel:4'd3,  sw:1, mode:0, exp_first:4'd3,  exp_n:1,  exp_last:4'd3,  exp_cnt:-1};
    vecs[2] = '{cfg:0, sel:4'd9,  sw:1, mode:0, exp_first:4'd0,  exp_n:16, exp_last:4'd15, exp_cnt:-1};
    vecs[3] = '{cfg:1, sel:4'd15, sw:0, mode:2, exp_first:4'd15, exp_n:1,  exp_last:4'd15, exp_cnt:16};

    reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_sel_i = '0; sweep_start_i = 1'b0; gen_tick_i = 1'b0;
    cfg_v2 = 1'b0; sel2 = '0; sweep2 = 1'b0; tick2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gen_reset",  0, 32'(gen_reset_o),  32'd1);
    chk("rst_gen_select", 0, 32'(gen_select_o), 32'd0);
    chk("rst_cfg_ready",  0, 32'(cfg_ready_o),  32'd1);
    chk("rst_meas_v",     0, 32'(meas_v_o),     32'd0);
    chk("rst_meas_sel",   0, 32'(meas_sel_o),   32'd0);
    chk("rst_meas_count", 0, 32'(meas_count_o), 32'd0);
    chk("rst_busy",       0, 32'(busy_o),       32'd0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    m_gsel = '0; m_grst = 1'b1; m_msel = '0; m_mcnt = '0;

    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      gen_tick_i = 1'($urandom % 2);
      @(negedge clk);
      chk("idle_gen_reset", c, 32'(gen_reset_o), 32'd1);
      chk("idle_busy",      c, 32'(busy_o),      32'd0);
    end

    for (int k = 0; k < 4; k++) begin
      run_seq(vecs[k], 1'b0);
      chk("vec_last_sel", k, 32'(gen_select_o), 32'(vecs[k].exp_last));
      chk("vec_meas_sel", k, 32'(meas_sel_o),   32'(vecs[k].exp_last));
      if (vecs[k].exp_cnt >= 0)
        chk("vec_count", k, 32'(meas_count_o), 32'(vecs[k].exp_cnt));
    end

    for (int k = 0; k < 6; k++) begin
      rv.cfg  = bit'($urandom % 2);
      rv.sw   = rv.cfg ? bit'($urandom % 2) : 1'b1;
      rv.sel  = 4'($urandom);
      rv.mode = 0;
      rv.exp_first = rv.cfg ? rv.sel : 4'd0;
      rv.exp_n     = rv.cfg ? 1 : 16;
      rv.exp_last  = rv.exp_first + 4'(rv.exp_n - 1);
      rv.exp_cnt   = -1;
      run_seq(rv, 1'b1);
    end

    // Reset during MEASURE of sweep select 7.
    pulses = 0;
    for (int c = 0; c <= 337; c++) begin
      @(posedge clk); #1;
      sweep_start_i = (c == 0);
      cfg_v_i = 1'b0;
      gen_tick_i = 1'($urandom % 2);
      if (c == 337) reset_n_i = 1'b0;
      @(negedge clk);
      if (meas_v_o) pulses++;
      if (c == 337) chk("mid_gen_select", c, 32'(gen_select_o), 32'd7);
    end
    chk("mid_pulses", 337, pulses, 7);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",       338, 32'(busy_o),       32'd0);
    chk("mid_rst_gen_reset",  338, 32'(gen_reset_o),  32'd1);
    chk("mid_rst_gen_select", 338, 32'(gen_select_o), 32'd0);
    chk("mid_rst_meas_v",     338, 32'(meas_v_o),     32'd0);
    chk("mid_rst_meas_count", 338, 32'(meas_count_o), 32'd0);
    chk("mid_rst_meas_sel",   338, 32'(meas_sel_o),   32'd0);
    chk("mid_rst_cfg_ready",  338, 32'(cfg_ready_o),  32'd1);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      gen_tick_i = 1'($urandom % 2);
      @(negedge clk);
      if (meas_v_o || busy_o || !gen_reset_o) bad++;
    end
    chk("post_rst_quiet", 60, bad, 0);

    // Saturation with a 600-cycle window and a tick toggling every cycle.
    seen = 1'b0; at = -1;
    for (int c = 0; c < 700 && !seen; c++) begin
      @(posedge clk); #1;
      cfg_v2 = (c == 0);
      sel2   = 4'd9;
      tick2  = 1'(c % 2);
      @(negedge clk);
      if (mv2) begin
        seen = 1'b1;
        at = c;
        chk("sat_count", c, 32'(mcnt2), 32'd255);
        chk("sat_sel",   c, 32'(msel2), 32'd9);
      end
    end
    chk("sat_seen",  at, 32'(seen), 32'd1);
    chk("sat_cycle", at, at, H + S + 600 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
